// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_pkg
//  Description : Shared button indices and repeat-FSM encoding for the RTC
//                input stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package rtc_pkg;

    localparam int unsigned BTN_SUBIR = 0;
    localparam int unsigned BTN_BAJAR = 1;
    localparam int unsigned BTN_IZQ   = 2;
    localparam int unsigned BTN_DER   = 3;
    localparam int unsigned BTN_PROG  = 4;
    localparam int unsigned N_BTN     = 5;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // Opposing buttons sit on adjacent even/odd indices.
    function automatic int unsigned btn_partner(input int unsigned idx);
        return idx ^ 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_bit
//  Description : Two-flop synchroniser plus stable-count debouncer, one bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit #(
    parameter int unsigned DEB_CYC = 500000,
    parameter int unsigned CNT_W   = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(DEB_CYC - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_flip;

    assign w_diff = r_sync ^ r_level;
    assign w_flip = w_diff && (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            if (!w_diff || w_flip) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_flip) begin
                r_level <= ~r_level;
            end
        end
    end

    // Strobes are valid in the cycle before the new level becomes visible.
    assign o_level = r_level;
    assign o_rise  = w_flip & ~r_level;
    assign o_fall  = w_flip &  r_level;

endmodule
`default_nettype wire

// File: rtl/acondicionador_botones.sv
`default_nettype none
// ============================================================================
//  Module      : acondicionador_botones
//  Description : Debounced levels, press pulses, auto-repeat and opposing-pair
//                lockout for the five RTC push-buttons.
//  Revision    : 1.0 - initial release
// ============================================================================
module acondicionador_botones
    import rtc_pkg::*;
#(
    parameter int unsigned DEB_CYC    = 500000,
    parameter int unsigned REP_DELAY  = 50000000,
    parameter int unsigned REP_PERIOD = 10000000,
    parameter logic [4:0]  REP_MASK   = 5'b00011,
    parameter int unsigned CNT_W      = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_raw,
    output logic [4:0] pulse,
    output logic [4:0] level,
    output logic       prog_level
);

    localparam logic [CNT_W-1:0] c_delay_last  = CNT_W'(REP_DELAY - 1);
    localparam logic [CNT_W-1:0] c_period_last = CNT_W'(REP_PERIOD - 1);

    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] w_fall;
    logic [N_BTN-1:0] w_lvl_nxt;
    logic [N_BTN-1:0] w_lock;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        logic [1:0]       r_state;
        logic [CNT_W-1:0] r_timer;
        logic             r_pulse;

        debounce_bit #(
            .DEB_CYC (DEB_CYC),
            .CNT_W   (CNT_W)
        ) u_deb (
            .clk     (clk),
            .rst     (rst),
            .i_raw   (btn_raw[g]),
            .o_level (level[g]),
            .o_rise  (w_rise[g]),
            .o_fall  (w_fall[g])
        );

        // Decisions use the level that will be visible alongside the pulse.
        assign w_lvl_nxt[g] = (level[g] | w_rise[g]) & ~w_fall[g];

        if (g < BTN_PROG) begin : g_lock
            localparam int unsigned c_partner = btn_partner(g);
            assign w_lock[g] = w_lvl_nxt[g] & w_lvl_nxt[c_partner];
        end else begin : g_free
            assign w_lock[g] = 1'b0;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= ST_IDLE;
                r_timer <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_pulse <= 1'b0;
                if (w_lock[g]) begin
                    r_state <= ST_IDLE;
                    r_timer <= '0;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            r_timer <= '0;
                            if (w_rise[g]) begin
                                r_pulse <= 1'b1;
                                if (REP_MASK[g]) begin
                                    r_state <= ST_WAIT;
                                end
                            end
                        end
                        ST_WAIT: begin
                            if (!w_lvl_nxt[g]) begin
                                r_state <= ST_IDLE;
                                r_timer <= '0;
                            end else if (r_timer == c_delay_last) begin
                                r_state <= ST_REPEAT;
                                r_timer <= '0;
                                r_pulse <= 1'b1;
                            end else begin
                                r_timer <= r_timer + CNT_W'(1);
                            end
                        end
                        ST_REPEAT: begin
                            if (!w_lvl_nxt[g]) begin
                                r_state <= ST_IDLE;
                                r_timer <= '0;
                            end else if (r_timer == c_period_last) begin
                                r_timer <= '0;
                                r_pulse <= 1'b1;
                            end else begin
                                r_timer <= r_timer + CNT_W'(1);
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_timer <= '0;
                        end
                    endcase
                end
            end
        end

        assign pulse[g] = r_pulse;
    end

    assign prog_level = level[BTN_PROG];

endmodule
`default_nettype wire

// File: tb/tb_acondicionador_botones.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acondicionador_botones
//  Description : Randomised and scenario stimulus against a hold-time model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acondicionador_botones;

    localparam int unsigned DEB = 4;
    localparam int unsigned RD  = 20;
    localparam int unsigned RP  = 5;
    localparam logic [4:0]  MASK = 5'b00011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn_raw = '0;
    logic [4:0] pulse;
    logic [4:0] level;
    logic       prog_level;

    always #5 clk = ~clk;

    acondicionador_botones #(
        .DEB_CYC    (DEB),
        .REP_DELAY  (RD),
        .REP_PERIOD (RP),
        .REP_MASK   (MASK),
        .CNT_W      (26)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .pulse      (pulse),
        .level      (level),
        .prog_level (prog_level)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: raw seen two edges late, level accepted after DEB mismatching
    // cycles, pulses derived from how long the accepted press has been held.
    logic [4:0] m_s1, m_s2, m_lvl, m_pulse;
    int         m_run  [5];
    int         m_held [5];
    bit         m_ok   [5];

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [4:0] nl;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0;
            for (int i = 0; i < 5; i++) begin
                m_run[i] = 0; m_held[i] = -1; m_ok[i] = 1'b0;
            end
        end else begin
            nl = m_lvl;
            for (int i = 0; i < 5; i++) begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        nl[i] = ~m_lvl[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
            for (int i = 0; i < 5; i++) begin
                if (nl[i] && !m_lvl[i]) begin
                    m_held[i] = 0; m_ok[i] = 1'b1;
                end else if (nl[i]) begin
                    m_held[i]++;
                end else begin
                    m_held[i] = -1; m_ok[i] = 1'b0;
                end
            end
            if (nl[0] && nl[1]) begin m_ok[0] = 1'b0; m_ok[1] = 1'b0; end
            if (nl[2] && nl[3]) begin m_ok[2] = 1'b0; m_ok[3] = 1'b0; end
            for (int i = 0; i < 5; i++) begin
                m_pulse[i] = nl[i] && m_ok[i] &&
                             (m_held[i] == 0 ||
                              (MASK[i] && m_held[i] >= int'(RD) &&
                               (m_held[i] - int'(RD)) % int'(RP) == 0));
            end
            m_lvl = nl;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("level", level, m_lvl);
        check("pulse", pulse, m_pulse);
        check("prog_level", 5'(prog_level), 5'(m_lvl[4]));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        run(4);

        // Clean press with auto-repeat, then release.
        btn_raw[0] = 1'b1;
        run(5);
        check("s1_level_before", 5'(level[0]), 5'd0);
        tick();
        check("s1_level_rise", 5'(level[0]), 5'd1);
        check("s1_press_pulse", 5'(pulse[0]), 5'd1);
        run(34);
        btn_raw[0] = 1'b0;
        run(15);

        // Short glitch.
        btn_raw[2] = 1'b1;
        run(3);
        btn_raw[2] = 1'b0;
        run(12);

        // Bouncing press on a non-repeating button.
        for (int k = 0; k < 6; k++) begin
            btn_raw[3] = ~btn_raw[3];
            run(2);
        end
        btn_raw[3] = 1'b1;
        run(40);
        btn_raw[3] = 1'b0;
        run(12);

        // Opposing-pair lockout.
        btn_raw[0] = 1'b1;
        run(16);
        btn_raw[1] = 1'b1;
        run(14);
        btn_raw[1] = 1'b0;
        run(40);
        btn_raw[0] = 1'b0;
        run(12);
        btn_raw[0] = 1'b1;
        run(12);
        btn_raw[0] = 1'b0;
        run(12);

        // Reset while repeating.
        btn_raw[0] = 1'b1;
        run(35);
        rst = 1'b1;
        tick();
        check("s5_all_clear", level | pulse, 5'd0);
        rst = 1'b0;
        run(30);
        btn_raw[0] = 1'b0;
        run(12);

        // prog held.
        btn_raw[4] = 1'b1;
        run(50);
        btn_raw[4] = 1'b0;
        run(12);

        // Random phases: fast bouncing, then long holds for repeats.
        for (int ph = 0; ph < 8; ph++) begin
            for (int k = 0; k < 500; k++) begin
                for (int b = 0; b < 5; b++) begin
                    if ($urandom_range(0, (ph % 2 == 0) ? 7 : 60) == 0)
                        btn_raw[b] = ~btn_raw[b];
                end
                rst = ($urandom_range(0, 399) == 0);
                tick();
            end
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
